// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle logic/arithmetic ops finish one cycle
// after accept. Unsigned MUL (shift-add) and DIV (restoring) iterate over WIDTH
// cycles. Results and flags hold until the next done pulse.
module alu_mc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zerof,
  output logic             overf,
  output logic             carryf,
  output logic             err
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned M  = WIDTH - 1;

  localparam logic [OPW-1:0] OP_ADD = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_SUB = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_EQ  = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_AND = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_OR  = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_XOR = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_SHL = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_SHR = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_MUL = OPW'(8'h09);
  localparam logic [OPW-1:0] OP_DIV = OPW'(8'h0A);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   m_reg, hi_reg, lo_reg;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               go_calc;

  logic [WIDTH-1:0]   s_res, s_hi;
  logic               s_z, s_o, s_c, s_e;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] shl_w, shr_w;
  logic [SW-1:0]      sh;

  logic [WIDTH:0]     mul_sum, div_sh, div_diff;

  assign ready = (state != S_CALC);
  assign done  = (state == S_DONE);

  assign go_calc = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  // Single-cycle result and flags, computed straight from the inputs so they can
  // be registered on the accept edge itself.
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    sh    = b[SW-1:0];
    // Double-width shifts keep the last bit shifted out at a fixed position.
    shl_w = {{WIDTH{1'b0}}, a} << sh;
    shr_w = {a, {WIDTH{1'b0}}} >> sh;
    s_res = '0;
    s_hi  = '0;
    s_o   = 1'b0;
    s_c   = 1'b0;
    s_e   = 1'b0;
    case (op)
      OP_ADD: begin
        s_res = add_w[WIDTH-1:0];
        s_c   = add_w[WIDTH];
        s_o   = (a[M] == b[M]) && (add_w[M] != a[M]);
      end
      OP_SUB: begin
        s_res = sub_w[WIDTH-1:0];
        s_c   = sub_w[WIDTH];
        s_o   = (a[M] != b[M]) && (sub_w[M] != a[M]);
      end
      OP_EQ:  s_res = (a == b) ? WIDTH'(1) : '0;
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_SHL: begin
        s_res = shl_w[WIDTH-1:0];
        s_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        s_res = shr_w[2*WIDTH-1:WIDTH];
        s_c   = shr_w[WIDTH-1];
      end
      OP_MUL: ;
      OP_DIV: begin
        s_res = '1;
        s_hi  = a;
        s_e   = 1'b1;
      end
      default: s_e = 1'b1;
    endcase
    s_z = !s_e && (s_res == '0);
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
    div_sh   = {hi_reg, lo_reg[M]};
    div_diff = div_sh - {1'b0, m_reg};
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], lo_reg[M:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_reg[M-1:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {lo_reg[M-1:0], 1'b0};
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CALC: if (&cnt) state_nxt = S_DONE;
      default: begin
        if (start) state_nxt = go_calc ? S_CALC : S_DONE;
        else       state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, iteration registers and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      m_reg  <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
      res    <= '0;
      res_hi <= '0;
      zerof  <= 1'b0;
      overf  <= 1'b0;
      carryf <= 1'b0;
      err    <= 1'b0;
    end else if (state == S_CALC) begin
      hi_reg <= step_hi;
      lo_reg <= step_lo;
      cnt    <= cnt + SW'(1);
      if (&cnt) begin
        res    <= step_lo;
        res_hi <= step_hi;
        zerof  <= is_div ? (step_lo == '0) : ({step_hi, step_lo} == '0);
        overf  <= !is_div && (step_hi != '0);
        carryf <= 1'b0;
        err    <= 1'b0;
      end
    end else if (start) begin
      if (go_calc) begin
        is_div <= (op == OP_DIV);
        m_reg  <= (op == OP_DIV) ? b : a;
        lo_reg <= (op == OP_DIV) ? a : b;
        hi_reg <= '0;
        cnt    <= '0;
      end else begin
        res    <= s_res;
        res_hi <= s_hi;
        zerof  <= s_z;
        overf  <= s_o;
        carryf <= s_c;
        err    <= s_e;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: vector table through a scoreboard queue, plus
// hand-written sequences for held start, back-to-back ops, reset mid-MUL and
// a WIDTH=32 instance.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [7:0]  op;
  logic [15:0] a, b, res, res_hi;
  logic        ready, done, zerof, overf, carryf, err;

  logic        start32;
  logic [7:0]  op32;
  logic [31:0] a32, b32, res32, res_hi32;
  logic        ready32, done32, zerof32, overf32, carryf32, err32;

  alu_mc #(.WIDTH(16), .OPW(8)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .res(res), .res_hi(res_hi),
    .zerof(zerof), .overf(overf), .carryf(carryf), .err(err));

  alu_mc #(.WIDTH(32), .OPW(8)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .ready(ready32), .done(done32), .res(res32), .res_hi(res_hi32),
    .zerof(zerof32), .overf(overf32), .carryf(carryf32), .err(err32));

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, res, res_hi;
    logic        z, o, c, e;
    int unsigned lat;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[16];
  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency in edges counted from the accept edge (1 = done right after it).
  task automatic wait_done(output int unsigned lat);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic cmp_out(input string tag, input int unsigned lat);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".res"}, res, e.res);
    chk({tag, ".res_hi"}, res_hi, e.res_hi);
    chk({tag, ".flags_zocе"}, {zerof, overf, carryf, err}, {e.z, e.o, e.c, e.e});
    chk({tag, ".lat"}, lat, e.lat);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    sb.push_back(v);
    tick();
    start = 1'b0;
    wait_done(lat);
    cmp_out(tag, lat);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    logic bad;
    vec_t v;

    //               op     a        b        res      res_hi   z     o     c     e     lat
    tbl[0]  = '{8'h01, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{8'h01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{8'h0A, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 17};
    tbl[3]  = '{8'h0A, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{8'hFF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5]  = '{8'h04, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{8'h05, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{8'h06, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{8'h08, 16'h8001, 16'h0001, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[9]  = '{8'h07, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{8'h08, 16'h1234, 16'h0014, 16'h0123, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{8'h09, 16'd3,    16'd5,    16'd15,   16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17};
    tbl[12] = '{8'h09, 16'd0,    16'd7,    16'd0,    16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 17};
    tbl[13] = '{8'h02, 16'd5,    16'd5,    16'd0,    16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{8'h02, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[15] = '{8'h03, 16'd3,    16'd4,    16'd0,    16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    tick(); tick();
    chk("reset.ready", ready, 1);
    chk("reset.done", done, 0);
    chk("reset.res", res, 0);
    chk("reset.res_hi", res_hi, 0);
    chk("reset.flags", {zerof, overf, carryf, err}, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // MUL with start held high: busy-window starts ignored, ADD accepted in DONE.
    op = 8'h09; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    sb.push_back('{8'h09, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 17});
    tick();
    op = 8'h01; a = 16'd1; b = 16'd1;
    lat = 1; bad = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (ready !== 1'b0) bad = 1'b1;
      tick();
      lat++;
    end
    chk("mul_hold.ready_low", bad, 0);
    cmp_out("mul_hold", lat);
    sb.push_back('{8'h01, 16'd1, 16'd1, 16'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    tick();
    start = 1'b0;
    cmp_out("after_mul", 1);
    tick();
    chk("after_mul.idle", done, 0);

    // Back-to-back EQ, SUB, SHL.
    op = 8'h03; a = 16'd5; b = 16'd5; start = 1'b1;
    sb.push_back('{8'h03, 16'd5, 16'd5, 16'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    tick();
    cmp_out("b2b_eq", 1);
    op = 8'h02; a = 16'd3; b = 16'd5;
    sb.push_back('{8'h02, 16'd3, 16'd5, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    tick();
    cmp_out("b2b_sub", 1);
    op = 8'h07; a = 16'h8001; b = 16'd1;
    sb.push_back('{8'h07, 16'h8001, 16'd1, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    tick();
    cmp_out("b2b_shl", 1);
    start = 1'b0;
    tick();
    chk("b2b.done_drop", done, 0);

    // Reset during a MUL: immediate return to reset values, no late done.
    tick(); tick();
    op = 8'h09; a = 16'd3; b = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst_mid.busy", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ready", ready, 1);
    chk("rst_mid.done", done, 0);
    chk("rst_mid.res", res, 0);
    chk("rst_mid.flags", {zerof, overf, carryf, err}, 0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (done !== 1'b0) bad = 1'b1;
    end
    chk("rst_mid.no_done", bad, 0);

    // WIDTH=32: illegal op and MUL latency.
    op32 = 8'hFF; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    lat = 1;
    while (done32 !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("w32_ill.lat", lat, 1);
    chk("w32_ill.res", res32, 0);
    chk("w32_ill.err", err32, 1);
    tick();
    op32 = 8'h09; a32 = 32'h0001_0000; b32 = 32'h0001_0000; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    lat = 1;
    while (done32 !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("w32_mul.lat", lat, 33);
    chk("w32_mul.res", res32, 0);
    chk("w32_mul.res_hi", res_hi32, 1);
    chk("w32_mul.flags", {zerof32, overf32, carryf32, err32}, 4'b0100);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
